ibus_data_target: RTL and testbench

Responder side of the 16-bit ibus used by the systolic array FPGA tops. It decodes ren/wen transactions from an ibus initiator (a UART command bridge or a test-pattern driver) and serves a word-addressed data memory, a pointer-based streaming data port, and a control/status block. The control block issues a start pulse to the array and tracks its completion. A second read port lets the array fetch operands from the same memory.

---
 rtl/ibus_data_target.sv | 148 ++++++++++++++
 tb/tb_ibus_data_target.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ibus_data_target.sv
// ibus responder: word-addressed data memory, pointer-based streaming DATA port,
// and a CTRL/STATUS block that starts the array and tracks its completion.
module ibus_data_target #(
    parameter logic [15:0] BASE_ADR   = 16'h0000,
    parameter int unsigned DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ren,
    input  logic [15:0]           ibus_radr,
    output logic [15:0]           ibus_rdata,
    input  logic                  wen,
    input  logic [15:0]           ibus_wadr,
    input  logic [15:0]           ibus_wdata,
    input  logic [DEPTH_LOG2-1:0] arr_radr,
    output logic [15:0]           arr_rdata,
    output logic                  array_start,
    input  logic                  array_done,
    output logic                  busy
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    localparam logic [DEPTH_LOG2-1:0] OFF_CTRL   = DEPTH_LOG2'(0);
    localparam logic [DEPTH_LOG2-1:0] OFF_STATUS = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2-1:0] OFF_PTR    = DEPTH_LOG2'(2);
    localparam logic [DEPTH_LOG2-1:0] OFF_DATA   = DEPTH_LOG2'(3);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } run_state_t;

    run_state_t state, state_next;

    logic [15:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] ptr;
    logic                  done_q;
    logic                  start_accept;

    logic                  r_hit, w_hit;
    logic                  r_mem, r_reg, w_mem, w_reg;
    logic [DEPTH_LOG2-1:0] r_off, w_off;
    logic                  data_rd, data_wr, ptr_wr, ctrl_wr, status_w1c;
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_wadr;
    logic [15:0]           rd_next;

    assign r_hit = (ibus_radr[15:DEPTH_LOG2+1] == BASE_ADR[15:DEPTH_LOG2+1]);
    assign w_hit = (ibus_wadr[15:DEPTH_LOG2+1] == BASE_ADR[15:DEPTH_LOG2+1]);
    assign r_mem = ren & r_hit &  ibus_radr[DEPTH_LOG2];
    assign r_reg = ren & r_hit & ~ibus_radr[DEPTH_LOG2];
    assign w_mem = wen & w_hit &  ibus_wadr[DEPTH_LOG2];
    assign w_reg = wen & w_hit & ~ibus_wadr[DEPTH_LOG2];
    assign r_off = ibus_radr[DEPTH_LOG2-1:0];
    assign w_off = ibus_wadr[DEPTH_LOG2-1:0];

    assign data_rd    = r_reg & (r_off == OFF_DATA);
    assign data_wr    = w_reg & (w_off == OFF_DATA);
    assign ptr_wr     = w_reg & (w_off == OFF_PTR);
    assign ctrl_wr    = w_reg & (w_off == OFF_CTRL) & ibus_wdata[0];
    assign status_w1c = w_reg & (w_off == OFF_STATUS) & ibus_wdata[1];

    // Direct memory writes and DATA-port writes share the single write port;
    // only one ibus write can occur per cycle, so they never conflict.
    assign mem_we   = w_mem | data_wr;
    assign mem_wadr = w_mem ? w_off : ptr;

    assign busy = (state == S_RUN);

    always_comb begin
        rd_next = '0;
        if (r_mem) begin
            rd_next = mem[r_off];
        end else if (r_reg) begin
            case (r_off)
                OFF_STATUS: rd_next = {{14{1'b0}}, done_q, busy};
                OFF_PTR:    rd_next = 16'(ptr);
                OFF_DATA:   rd_next = mem[ptr];
                default:    rd_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wadr] <= ibus_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ibus_rdata <= '0;
            arr_rdata  <= '0;
        end else begin
            if (ren) begin
                ibus_rdata <= rd_next;
            end
            arr_rdata <= mem[arr_radr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (ptr_wr) begin
            ptr <= ibus_wdata[DEPTH_LOG2-1:0];
        end else if (data_rd | data_wr) begin
            ptr <= ptr + DEPTH_LOG2'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            array_start <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_next;
            array_start <= start_accept;
            if (array_done) begin
                done_q <= 1'b1;
            end else if (status_w1c) begin
                done_q <= 1'b0;
            end
        end
    end

    // A start is only accepted from idle, so a CTRL write coinciding with
    // array_done during a run is dropped while the run completes.
    always_comb begin
        state_next   = state;
        start_accept = 1'b0;
        case (state)
            S_IDLE: begin
                if (ctrl_wr) begin
                    state_next   = S_RUN;
                    start_accept = 1'b1;
                end
            end
            S_RUN: begin
                if (array_done) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_ibus_data_target.sv
// Randomized self-checking bench for ibus_data_target against a transaction-level model.
module tb_ibus_data_target;
    localparam logic [15:0] BASE     = 16'h0000;
    localparam logic [15:0] A_CTRL   = BASE + 16'h0000;
    localparam logic [15:0] A_STATUS = BASE + 16'h0001;
    localparam logic [15:0] A_PTR    = BASE + 16'h0002;
    localparam logic [15:0] A_DATA   = BASE + 16'h0003;
    localparam logic [15:0] A_MEM    = BASE + 16'h0040;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ren = 1'b0;
    logic [15:0] ibus_radr = '0;
    logic [15:0] ibus_rdata;
    logic        wen = 1'b0;
    logic [15:0] ibus_wadr = '0;
    logic [15:0] ibus_wdata = '0;
    logic [5:0]  arr_radr = '0;
    logic [15:0] arr_rdata;
    logic        array_start;
    logic        array_done = 1'b0;
    logic        busy;

    ibus_data_target #(.BASE_ADR(BASE), .DEPTH_LOG2(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .ren(ren), .ibus_radr(ibus_radr), .ibus_rdata(ibus_rdata),
        .wen(wen), .ibus_wadr(ibus_wadr), .ibus_wdata(ibus_wdata),
        .arr_radr(arr_radr), .arr_rdata(arr_rdata),
        .array_start(array_start), .array_done(array_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Model state: memory with known-flags (contents undefined after reset)
    logic [15:0] m_mem   [64];
    logic        m_known [64];
    logic [5:0]  m_ptr;
    logic        m_busy, m_done, m_start;
    logic [15:0] m_rdata, m_arr;
    logic        m_rd_known, m_arr_known;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_ptr = '0; m_busy = 1'b0; m_done = 1'b0; m_start = 1'b0;
        m_rdata = '0; m_arr = '0; m_rd_known = 1'b1; m_arr_known = 1'b1;
        for (int i = 0; i < 64; i++) m_known[i] = 1'b0;
    endtask

    task automatic model_step(input logic r, input logic [15:0] ra, input logic w,
                              input logic [15:0] wa, input logic [15:0] wd,
                              input logic [5:0] aa, input logic dn);
        logic [5:0] old_ptr;
        logic start, data_acc, ptr_wr, clr;
        old_ptr = m_ptr; start = 1'b0; data_acc = 1'b0; ptr_wr = 1'b0; clr = 1'b0;
        if (r) begin
            m_rdata = '0; m_rd_known = 1'b1;
            if (ra[15:7] == BASE[15:7]) begin
                if (ra[6]) begin
                    m_rdata = m_mem[ra[5:0]]; m_rd_known = m_known[ra[5:0]];
                end else begin
                    case (ra[5:0])
                        6'd1: m_rdata = {14'b0, m_done, m_busy};
                        6'd2: m_rdata = {10'b0, m_ptr};
                        6'd3: begin
                            m_rdata = m_mem[old_ptr]; m_rd_known = m_known[old_ptr];
                            data_acc = 1'b1;
                        end
                        default: m_rdata = '0;
                    endcase
                end
            end
        end
        m_arr = m_mem[aa]; m_arr_known = m_known[aa];
        if (w && wa[15:7] == BASE[15:7]) begin
            if (wa[6]) begin
                m_mem[wa[5:0]] = wd; m_known[wa[5:0]] = 1'b1;
            end else begin
                case (wa[5:0])
                    6'd0: if (wd[0] && !m_busy) start = 1'b1;
                    6'd1: clr = wd[1];
                    6'd2: begin m_ptr = wd[5:0]; ptr_wr = 1'b1; end
                    6'd3: begin
                        m_mem[old_ptr] = wd; m_known[old_ptr] = 1'b1; data_acc = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
        if (data_acc && !ptr_wr) m_ptr = old_ptr + 6'd1;
        if (dn) m_done = 1'b1;
        else if (clr) m_done = 1'b0;
        if (dn && m_busy) m_busy = 1'b0;
        else if (start) m_busy = 1'b1;
        m_start = start;
    endtask

    task automatic compare_all();
        if (m_rd_known) chk("ibus_rdata", ibus_rdata, m_rdata);
        if (m_arr_known) chk("arr_rdata", arr_rdata, m_arr);
        chk("array_start", {15'b0, array_start}, {15'b0, m_start});
        chk("busy", {15'b0, busy}, {15'b0, m_busy});
    endtask

    task automatic step(input logic r, input logic [15:0] ra, input logic w,
                        input logic [15:0] wa, input logic [15:0] wd,
                        input logic [5:0] aa, input logic dn);
        ren = r; ibus_radr = ra; wen = w; ibus_wadr = wa; ibus_wdata = wd;
        arr_radr = aa; array_done = dn;
        @(posedge clk);
        model_step(r, ra, w, wa, wd, aa, dn);
        #1;
        compare_all();
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        step(1'b0, '0, 1'b1, a, d, '0, 1'b0);
    endtask

    task automatic rd(input logic [15:0] a);
        step(1'b1, a, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    function automatic logic [15:0] rand_adr();
        int unsigned sel;
        sel = $urandom_range(99);
        if (sel < 50) return A_MEM + 16'($urandom_range(63));
        if (sel < 85) return BASE + 16'($urandom_range(3));
        if (sel < 95) return BASE + 16'($urandom_range(63, 4));
        return BASE ^ (16'($urandom_range(511, 1)) << 7);
    endfunction

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata", ibus_rdata, 16'h0000);
        chk("rst_arr", arr_rdata, 16'h0000);
        chk("rst_start", {15'b0, array_start}, 16'h0000);
        chk("rst_busy", {15'b0, busy}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 64; i++) wr(A_MEM + 16'(i), 16'($urandom));

        wr(A_MEM, 16'hA5A5);
        rd(A_MEM);            chk("mem_rd", ibus_rdata, 16'hA5A5);
        rd(BASE + 16'h0004);  chk("unmapped_rd", ibus_rdata, 16'h0000);
        idle();               chk("rdata_hold", ibus_rdata, 16'h0000);

        wr(A_PTR, 16'h003E);
        for (int i = 1; i <= 4; i++) wr(A_DATA, 16'(i));
        rd(A_PTR);            chk("ptr_wrap", ibus_rdata, 16'h0002);
        rd(A_MEM + 16'h3E);   chk("stream0", ibus_rdata, 16'h0001);
        rd(A_MEM + 16'h3F);   chk("stream1", ibus_rdata, 16'h0002);
        rd(A_MEM + 16'h00);   chk("stream2", ibus_rdata, 16'h0003);
        rd(A_MEM + 16'h01);   chk("stream3", ibus_rdata, 16'h0004);

        wr(A_CTRL, 16'h0001); chk("start_pulse", {15'b0, array_start}, 16'h0001);
        rd(A_STATUS);         chk("status_busy", ibus_rdata, 16'h0001);
                              chk("start_once", {15'b0, array_start}, 16'h0000);
        wr(A_CTRL, 16'h0001); chk("start_ignored", {15'b0, array_start}, 16'h0000);
        step(1'b0, '0, 1'b0, '0, '0, '0, 1'b1);
        rd(A_STATUS);         chk("status_done", ibus_rdata, 16'h0002);
        wr(A_STATUS, 16'h0002);
        rd(A_STATUS);         chk("status_w1c", ibus_rdata, 16'h0000);

        wr(A_MEM + 16'h05, 16'h1111);
        step(1'b1, A_MEM + 16'h05, 1'b1, A_MEM + 16'h05, 16'h2222, '0, 1'b0);
        chk("rbw_old", ibus_rdata, 16'h1111);
        rd(A_MEM + 16'h05);   chk("rbw_new", ibus_rdata, 16'h2222);
        step(1'b0, '0, 1'b1, A_STATUS, 16'h0002, '0, 1'b1);
        rd(A_STATUS);         chk("done_set_wins", ibus_rdata, 16'h0002);
        wr(A_CTRL, 16'h0001);
        step(1'b0, '0, 1'b1, A_CTRL, 16'h0001, '0, 1'b1);
        chk("start_done_busy", {15'b0, busy}, 16'h0000);
        chk("start_done_pulse", {15'b0, array_start}, 16'h0000);

        wr(A_MEM + 16'h07, 16'hBEEF);
        step(1'b0, '0, 1'b0, '0, '0, 6'd7, 1'b0);
        chk("arr_port", arr_rdata, 16'hBEEF);

        wr(A_PTR, 16'h000A);
        step(1'b1, A_DATA, 1'b1, A_DATA, 16'h5555, '0, 1'b0);
        rd(A_PTR);            chk("data_rw_ptr", ibus_rdata, 16'h000B);
        rd(A_MEM + 16'h0A);   chk("data_rw_new", ibus_rdata, 16'h5555);

        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(99) < 60), rand_adr(),
                 ($urandom_range(99) < 60), rand_adr(), 16'($urandom),
                 6'($urandom_range(63)), ($urandom_range(99) < 5));
        end

        wr(A_STATUS, 16'h0002);
        if (busy) step(1'b0, '0, 1'b0, '0, '0, '0, 1'b1);
        wr(A_CTRL, 16'h0001);
        wr(A_PTR, 16'h0009);
        wr(A_MEM + 16'h02, 16'h7777);
        rd(A_MEM + 16'h02);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {15'b0, busy}, 16'h0000);
        chk("arst_start", {15'b0, array_start}, 16'h0000);
        chk("arst_rdata", ibus_rdata, 16'h0000);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        rd(A_PTR);            chk("arst_ptr", ibus_rdata, 16'h0000);
        rd(A_STATUS);         chk("arst_status", ibus_rdata, 16'h0000);
        repeat (4) idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
